axi_ram_responder: RTL and testbench
====================================

// Module: axi_ram_responder
// PURPOSE
//  AXI4 slave (responder) on a 32-bit block RAM; the target of the loader's AR/AW bursts.
//  Serves INCR/FIXED read bursts into the ALU stream path.
//  Accepts write bursts from the ALU result stream.
//  Independent read and write engines on a simple dual-port array.
//  Read-during-write is read-first.
// PARAMETERS
//  depth_words  16384  array depth in 32-bit words (power of 2); byte space = depth_words*4
//  id_width     5      width of AR/AW/R/B ID fields
// PORTS
//  clock        in   1         single clock; all logic posedge
//  reset_n      in   1         asynchronous, active-low reset
//  ram_araddr   in   32        read burst start byte address
//  ram_arburst  in   2         2'b00 FIXED, 2'b01 INCR, other -> SLVERR
//  ram_arid     in   id_width  read ID
//  ram_arlen    in   8         beats-1
//  ram_arsize   in   3         must be 3'd2
//  ram_arvalid  in   1         AR valid
//  ram_arready  out  1         AR ready
//  ram_rdata    out  32        read data
//  ram_rid      out  id_width  = latched arid
//  ram_rresp    out  2         2'b00 OKAY / 2'b10 SLVERR
//  ram_rlast    out  1         final beat
//  ram_rvalid   out  1         R valid
//  ram_rready   in   1         R ready
//  ram_aw*      in/out         same set/meaning as AR (awaddr, awburst, awid, awlen, awsize, awvalid, awready)
//  ram_wdata    in   32        write data
//  ram_wstrb    in   4         byte enables
//  ram_wlast    in   1         final write beat
//  ram_wvalid   in   1         W valid
//  ram_wready   out  1         W ready
//  ram_bid      out  id_width  = latched awid
//  ram_bresp    out  2         OKAY / SLVERR
//  ram_bvalid   out  1         B valid
//  ram_bready   in   1         B ready
// BEHAVIOUR
//  Reset: arready, awready, wready, rvalid, rlast, bvalid = 0; rdata, rresp, bresp = 0.
//  Reset: FSMs -> IDLE. Array contents are not cleared.
//  First rising edge after reset_n release sets arready = awready = 1.
//  Reset mid-burst aborts the burst silently; no R/B beat is issued for it.
//  Read FSM R_IDLE -> R_BURST:
//   - R_IDLE: arready=1; on arvalid&arready latch addr/len/id/burst/size, clear beat count, arready=0.
//   - R_BURST: one-cycle BRAM latency; first rvalid 2 cycles after the AR handshake.
//   - Back-to-back beats at 1/cycle while rready=1.
//   - rvalid=1 & rready=0: rdata/rresp/rlast/rid held stable.
//   - Memory read is re-issued only when the output register is empty or being consumed.
//   - rlast=1 on beat count == arlen.
//   - rvalid&rready&rlast -> R_IDLE with arready=1 the next cycle.
//  Write FSM W_IDLE -> W_DATA -> W_RESP:
//   - W_IDLE: awready=1; latch AW fields on handshake.
//   - W_DATA: wready=1; each wvalid&wready beat writes bytes with wstrb bit set.
//   - Burst ends on the beat with wlast=1 -> W_RESP.
//   - Beats past awlen+1 are accepted and discarded.
//   - wlast count mismatch (early or late) -> bresp=SLVERR.
//   - W_RESP: bvalid=1 held until bready; then W_IDLE, awready=1 the next cycle.
//  Address arithmetic:
//   - Word index = addr[clog2(depth_words)+1:2]; addr[1:0] ignored.
//   - INCR: +4 bytes per beat, 32-bit, no wrap. FIXED: same address every beat.
//  Error beats: byte addr >= depth_words*4, or size!=2, or burst not in {00,01}.
//   - Read: beat returns rdata=0, rresp=SLVERR.
//   - Write: beat is discarded; bresp=SLVERR if any beat erred.
//   - Valid and erroring beats within a burst each get their own rresp.
//  Simultaneous: read and write engines run concurrently.
//   - Same word read/written in one cycle: read returns pre-write data.
//  Beat counters are 8 bits wide; arlen=255 gives exactly 256 beats.
// TESTING
//  1. Write INCR addr 0x0100, len 3, data 1..4, strb F -> bresp OKAY, bid=awid.
//     Then read same -> 1,2,3,4; rlast on 4th beat only.
//  2. Read FIXED 0x0040, len 7 after writing 0xA5A5A5A5 -> 8 beats of 0xA5A5A5A5, OKAY.
//  3. rready toggled 1010... during a len 15 read -> 16 beats in order.
//     rdata stable while stalled; no beat lost or duplicated.
//  4. Write strb 4'b0101, data 0xDDCCBBAA over 0x11223344 -> readback 0x11CC33AA.
//  5. Read 0xFFFC (depth 16384), len 1 -> beat0 OKAY, beat1 rdata=0 SLVERR.
//     Write awsize=1 -> all beats discarded, bresp SLVERR.
//  6. Write with wlast on beat 2 of len 3 -> bresp SLVERR.
//     reset_n pulsed low mid-read -> rvalid=0 immediately; arready=1 one edge after release.

Source files
------------

// File: rtl/axi_ram_responder.sv
// axi_ram_responder: AXI4 slave on a byte-enabled simple dual-port RAM with
// independent read (INCR/FIXED bursts, registered BRAM read) and write engines.
module axi_ram_responder #(
    parameter int depth_words = 16384,
    parameter int id_width    = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [31:0]         ram_araddr,
    input  logic [1:0]          ram_arburst,
    input  logic [id_width-1:0] ram_arid,
    input  logic [7:0]          ram_arlen,
    input  logic [2:0]          ram_arsize,
    input  logic                ram_arvalid,
    output logic                ram_arready,
    output logic [31:0]         ram_rdata,
    output logic [id_width-1:0] ram_rid,
    output logic [1:0]          ram_rresp,
    output logic                ram_rlast,
    output logic                ram_rvalid,
    input  logic                ram_rready,
    input  logic [31:0]         ram_awaddr,
    input  logic [1:0]          ram_awburst,
    input  logic [id_width-1:0] ram_awid,
    input  logic [7:0]          ram_awlen,
    input  logic [2:0]          ram_awsize,
    input  logic                ram_awvalid,
    output logic                ram_awready,
    input  logic [31:0]         ram_wdata,
    input  logic [3:0]          ram_wstrb,
    input  logic                ram_wlast,
    input  logic                ram_wvalid,
    output logic                ram_wready,
    output logic [id_width-1:0] ram_bid,
    output logic [1:0]          ram_bresp,
    output logic                ram_bvalid,
    input  logic                ram_bready
);
    localparam int aw = $clog2(depth_words);
    localparam logic [32:0] byte_limit = 33'(depth_words) << 2;

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    function automatic logic beat_err(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] burst);
        return ({1'b0, addr} >= byte_limit) || (size != 3'd2) || burst[1];
    endfunction

    logic [31:0] mem [depth_words];

    r_state_t    r_state;
    logic [31:0] r_addr;
    logic [7:0]  r_len, r_cnt;
    logic [1:0]  r_burst;
    logic [2:0]  r_size;
    logic        r_prime, r_issued;
    logic        r_err, r_load;
    logic [aw-1:0] r_idx;

    w_state_t    w_state;
    logic [31:0] w_addr;
    logic [7:0]  w_len, w_cnt;
    logic [1:0]  w_burst;
    logic [2:0]  w_size;
    logic        w_over, w_err;
    logic        w_beat, w_berr, w_we;
    logic [aw-1:0] w_idx;

    // r_prime models the BRAM address phase; a beat is fetched only when the output slot frees up
    always_comb begin
        r_err  = beat_err(r_addr, r_size, r_burst);
        r_idx  = r_addr[aw+1:2];
        r_load = (r_state == R_BURST) && r_prime && !r_issued && (!ram_rvalid || ram_rready);
        w_beat = ram_wvalid && ram_wready;
        w_berr = beat_err(w_addr, w_size, w_burst);
        w_we   = w_beat && !w_over && !w_berr;
        w_idx  = w_addr[aw+1:2];
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++)
            if (w_we && ram_wstrb[b]) mem[w_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= R_IDLE;
            ram_arready <= 1'b0;
            ram_rvalid  <= 1'b0;
            ram_rlast   <= 1'b0;
            ram_rdata   <= '0;
            ram_rresp   <= '0;
            ram_rid     <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_burst     <= '0;
            r_size      <= '0;
            r_prime     <= 1'b0;
            r_issued    <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ram_arready <= !(ram_arvalid && ram_arready);
                    if (ram_arvalid && ram_arready) begin
                        r_addr   <= ram_araddr;
                        r_len    <= ram_arlen;
                        r_burst  <= ram_arburst;
                        r_size   <= ram_arsize;
                        ram_rid  <= ram_arid;
                        r_cnt    <= '0;
                        r_prime  <= 1'b0;
                        r_issued <= 1'b0;
                        r_state  <= R_BURST;
                    end
                end
                default: begin
                    r_prime <= 1'b1;
                    if (r_load) begin
                        ram_rvalid <= 1'b1;
                        ram_rdata  <= r_err ? '0 : mem[r_idx];
                        ram_rresp  <= r_err ? 2'b10 : 2'b00;
                        ram_rlast  <= r_cnt == r_len;
                        r_issued   <= r_cnt == r_len;
                        r_cnt      <= r_cnt + 8'd1;
                        if (r_burst == 2'b01) r_addr <= r_addr + 32'd4;
                    end else if (ram_rvalid && ram_rready) begin
                        ram_rvalid <= 1'b0;
                        ram_rlast  <= 1'b0;
                        if (ram_rlast) begin
                            r_state     <= R_IDLE;
                            ram_arready <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // w_over marks that awlen+1 beats were already taken; later beats are dropped
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_state     <= W_IDLE;
            ram_awready <= 1'b0;
            ram_wready  <= 1'b0;
            ram_bvalid  <= 1'b0;
            ram_bresp   <= '0;
            ram_bid     <= '0;
            w_addr      <= '0;
            w_len       <= '0;
            w_cnt       <= '0;
            w_burst     <= '0;
            w_size      <= '0;
            w_over      <= 1'b0;
            w_err       <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    ram_awready <= !(ram_awvalid && ram_awready);
                    if (ram_awvalid && ram_awready) begin
                        w_addr     <= ram_awaddr;
                        w_len      <= ram_awlen;
                        w_burst    <= ram_awburst;
                        w_size     <= ram_awsize;
                        ram_bid    <= ram_awid;
                        w_cnt      <= '0;
                        w_over     <= 1'b0;
                        w_err      <= 1'b0;
                        ram_wready <= 1'b1;
                        w_state    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_cnt <= w_cnt + 8'd1;
                        if (w_burst == 2'b01) w_addr <= w_addr + 32'd4;
                        if (!w_over && w_cnt == w_len) w_over <= 1'b1;
                        if (!w_over && w_berr) w_err <= 1'b1;
                        if (ram_wlast) begin
                            ram_wready <= 1'b0;
                            ram_bvalid <= 1'b1;
                            ram_bresp  <= (w_err || w_berr || w_over || w_cnt != w_len) ? 2'b10 : 2'b00;
                            w_state    <= W_RESP;
                        end
                    end
                end
                default: begin
                    if (ram_bvalid && ram_bready) begin
                        ram_bvalid  <= 1'b0;
                        ram_awready <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ram_responder.sv
// tb_axi_ram_responder: directed and randomized bursts checked against a byte-level
// memory model that predicts every R beat and B response from the AXI rules.
module tb_axi_ram_responder;
    logic        clock = 0, reset_n = 0;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic [4:0]  arid, awid, rid, bid;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [3:0]  wstrb;
    logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic wlast, wvalid, wready, bvalid, bready;

    always #5 clock = ~clock;

    axi_ram_responder #(.depth_words(16384), .id_width(5)) dut (
        .clock(clock), .reset_n(reset_n),
        .ram_araddr(araddr), .ram_arburst(arburst), .ram_arid(arid), .ram_arlen(arlen),
        .ram_arsize(arsize), .ram_arvalid(arvalid), .ram_arready(arready),
        .ram_rdata(rdata), .ram_rid(rid), .ram_rresp(rresp), .ram_rlast(rlast),
        .ram_rvalid(rvalid), .ram_rready(rready),
        .ram_awaddr(awaddr), .ram_awburst(awburst), .ram_awid(awid), .ram_awlen(awlen),
        .ram_awsize(awsize), .ram_awvalid(awvalid), .ram_awready(awready),
        .ram_wdata(wdata), .ram_wstrb(wstrb), .ram_wlast(wlast), .ram_wvalid(wvalid),
        .ram_wready(wready), .ram_bid(bid), .ram_bresp(bresp), .ram_bvalid(bvalid),
        .ram_bready(bready)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, g, e, $time);
        end
    endtask

    typedef struct { logic [31:0] d; logic [31:0] m; logic [1:0] r; logic l; logic [4:0] id; } rexp_t;
    typedef struct { logic [1:0] r; logic [4:0] id; } bexp_t;

    logic [7:0] mm [0:65535];
    bit         kn [0:65535];
    rexp_t      rq [$];
    bexp_t      bq [$];

    logic        stall = 0;
    logic [31:0] prev_d;
    logic [7:0]  prev_c;
    logic [31:0] wa;
    logic [1:0]  wbu;
    logic [2:0]  wsz;
    logic [4:0]  widm;
    logic        werr;
    int          wk, wl;

    function automatic logic is_err(input logic [31:0] a, input logic [2:0] s, input logic [1:0] b);
        return (a >= 32'h10000) || (s != 3'd2) || (b > 2'd1);
    endfunction

    always @(negedge clock) begin : model
        logic [31:0] a;
        rexp_t x;
        bexp_t y;
        if (!reset_n) begin
            rq.delete();
            bq.delete();
            stall = 0;
        end else begin
            if (stall) begin
                chk("r_hold_valid", rvalid, 1);
                chk("r_hold_data", rdata, prev_d);
                chk("r_hold_ctl", {rresp, rlast, rid}, prev_c);
            end
            if (rvalid && rready) begin
                chk("r_queue", 32'(rq.size() != 0), 1);
                if (rq.size() != 0) begin
                    x = rq.pop_front();
                    chk("rdata", rdata & x.m, x.d & x.m);
                    chk("rresp", rresp, x.r);
                    chk("rlast", rlast, x.l);
                    chk("rid", rid, x.id);
                end
            end
            stall  = rvalid && !rready;
            prev_d = rdata;
            prev_c = {rresp, rlast, rid};
            if (arvalid && arready)
                for (int i = 0; i <= int'(arlen); i++) begin
                    a = (arburst == 2'b01) ? araddr + 32'(4 * i) : araddr;
                    x.d = '0;
                    x.m = '1;
                    if (!is_err(a, arsize, arburst))
                        for (int b = 0; b < 4; b++) begin
                            x.d[8*b +: 8] = mm[{a[15:2], 2'(b)}];
                            x.m[8*b +: 8] = kn[{a[15:2], 2'(b)}] ? 8'hFF : 8'h00;
                        end
                    x.r  = is_err(a, arsize, arburst) ? 2'b10 : 2'b00;
                    x.l  = (i == int'(arlen));
                    x.id = arid;
                    rq.push_back(x);
                end
            if (awvalid && awready) begin
                wa = awaddr; wbu = awburst; wsz = awsize; widm = awid; wl = int'(awlen);
                wk = 0; werr = 0;
            end
            if (wvalid && wready) begin
                a = (wbu == 2'b01) ? wa + 32'(4 * wk) : wa;
                if (wk <= wl) begin
                    if (is_err(a, wsz, wbu)) werr = 1;
                    else
                        for (int b = 0; b < 4; b++)
                            if (wstrb[b]) begin
                                mm[{a[15:2], 2'(b)}] = wdata[8*b +: 8];
                                kn[{a[15:2], 2'(b)}] = 1;
                            end
                end
                if (wlast) begin
                    y.r  = (werr || wk != wl) ? 2'b10 : 2'b00;
                    y.id = widm;
                    bq.push_back(y);
                end
                wk++;
            end
            if (bvalid && bready) begin
                chk("b_queue", 32'(bq.size() != 0), 1);
                if (bq.size() != 0) begin
                    y = bq.pop_front();
                    chk("bresp", bresp, y.r);
                    chk("bid", bid, y.id);
                end
            end
        end
    end

    logic [31:0] got_d [$];
    logic [1:0]  got_r [$];
    logic        got_l [$];
    logic [31:0] wd [0:299];
    logic [3:0]  ws [0:299];

    task automatic rd(input logic [31:0] addr, input logic [1:0] burst, input logic [4:0] id,
                      input logic [7:0] len, input logic [2:0] size, input int mode, output int lat);
        int t, cyc;
        logic done;
        araddr = addr; arburst = burst; arid = id; arlen = len; arsize = size; arvalid = 1;
        t = 0;
        do begin @(negedge clock); t++; end while (!arready && t < 200);
        chk("arready_wait", arready, 1);
        got_d.delete(); got_r.delete(); got_l.delete();
        lat = 0; cyc = 0; done = 0;
        while (!done && cyc < 2000) begin
            @(posedge clock); #1;
            arvalid = 0;
            cyc++;
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(1));
            @(negedge clock);
            if (rvalid && lat == 0) lat = cyc;
            if (rvalid && rready) begin
                got_d.push_back(rdata); got_r.push_back(rresp); got_l.push_back(rlast);
                done = rlast;
            end
        end
        chk("rlast_seen", done, 1);
        @(posedge clock); #1;
        rready = 0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [1:0] burst, input logic [4:0] id,
                      input logic [7:0] len, input logic [2:0] size, input int nbeats,
                      output logic [1:0] br, output logic [4:0] bi);
        int t;
        awaddr = addr; awburst = burst; awid = id; awlen = len; awsize = size; awvalid = 1;
        t = 0;
        do begin @(negedge clock); t++; end while (!awready && t < 200);
        chk("awready_wait", awready, 1);
        for (int i = 0; i < nbeats; i++) begin
            @(posedge clock); #1;
            awvalid = 0;
            wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
            t = 0;
            do begin @(negedge clock); t++; end while (!wready && t < 200);
            chk("wready_wait", wready, 1);
        end
        @(posedge clock); #1;
        wvalid = 0; wlast = 0; bready = 1;
        t = 0;
        do begin @(negedge clock); t++; end while (!bvalid && t < 200);
        chk("bvalid_wait", bvalid, 1);
        br = bresp; bi = bid;
        @(posedge clock); #1;
        bready = 0;
    endtask

    logic [1:0]  br;
    logic [4:0]  bi;
    int          lat, nb, sel;
    logic [31:0] exp3 [0:15];
    logic [31:0] ra;
    logic [1:0]  rb;
    logic [2:0]  rs;
    logic [7:0]  rl;

    initial begin
        {araddr, arburst, arid, arlen, arsize, arvalid, rready} = '0;
        {awaddr, awburst, awid, awlen, awsize, awvalid} = '0;
        {wdata, wstrb, wlast, wvalid, bready} = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bresp", bresp, 0);
        #2 reset_n = 1;
        chk("arready_before_edge", arready, 0);
        @(posedge clock); #1;
        chk("arready_after_release", arready, 1);
        chk("awready_after_release", awready, 1);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        wr(32'h100, 2'b01, 5'h0A, 8'd3, 3'd2, 4, br, bi);
        chk("t1_bresp", br, 2'b00);
        chk("t1_bid", bi, 5'h0A);
        rd(32'h100, 2'b01, 5'h03, 8'd3, 3'd2, 0, lat);
        chk("t1_latency", lat, 3);
        chk("t1_beats", got_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_data", got_d[i], 32'(i + 1));
            chk("t1_last", got_l[i], i == 3);
        end

        wd[0] = 32'hA5A5A5A5; ws[0] = 4'hF;
        wr(32'h40, 2'b01, 5'h01, 8'd0, 3'd2, 1, br, bi);
        rd(32'h40, 2'b00, 5'h02, 8'd7, 3'd2, 0, lat);
        chk("t2_beats", got_d.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_data", got_d[i], 32'hA5A5A5A5);
            chk("t2_resp", got_r[i], 2'b00);
        end

        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; exp3[i] = wd[i]; end
        wr(32'h200, 2'b01, 5'h04, 8'd15, 3'd2, 16, br, bi);
        rd(32'h200, 2'b01, 5'h06, 8'd15, 3'd2, 1, lat);
        chk("t3_beats", got_d.size(), 16);
        for (int i = 0; i < 16; i++) chk("t3_data", got_d[i], exp3[i]);

        wd[0] = 32'h11223344; ws[0] = 4'hF;
        wr(32'h300, 2'b01, 5'h05, 8'd0, 3'd2, 1, br, bi);
        wd[0] = 32'hDDCCBBAA; ws[0] = 4'b0101;
        wr(32'h300, 2'b01, 5'h05, 8'd0, 3'd2, 1, br, bi);
        rd(32'h300, 2'b01, 5'h07, 8'd0, 3'd2, 0, lat);
        chk("t4_merge", got_d[0], 32'h11CC33AA);

        wd[0] = 32'h5EEDBEEF; ws[0] = 4'hF;
        wr(32'hFFFC, 2'b01, 5'h08, 8'd0, 3'd2, 1, br, bi);
        rd(32'hFFFC, 2'b01, 5'h09, 8'd1, 3'd2, 0, lat);
        chk("t5_b0_data", got_d[0], 32'h5EEDBEEF);
        chk("t5_b0_resp", got_r[0], 2'b00);
        chk("t5_b1_data", got_d[1], 32'h0);
        chk("t5_b1_resp", got_r[1], 2'b10);
        chk("t5_b1_last", got_l[1], 1);
        wd[0] = 32'h12345678; wd[1] = 32'h9ABCDEF0; ws[0] = 4'hF; ws[1] = 4'hF;
        wr(32'h400, 2'b01, 5'h0B, 8'd1, 3'd2, 2, br, bi);
        chk("t5_ok_bresp", br, 2'b00);
        wd[0] = '1; wd[1] = '1;
        wr(32'h400, 2'b01, 5'h0C, 8'd1, 3'd1, 2, br, bi);
        chk("t5_size_bresp", br, 2'b10);
        rd(32'h400, 2'b01, 5'h0D, 8'd1, 3'd2, 0, lat);
        chk("t5_kept0", got_d[0], 32'h12345678);
        chk("t5_kept1", got_d[1], 32'h9ABCDEF0);

        for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        wr(32'h500, 2'b01, 5'h0E, 8'd3, 3'd2, 3, br, bi);
        chk("t6_early_bresp", br, 2'b10);
        wr(32'h600, 2'b01, 5'h0F, 8'd1, 3'd2, 3, br, bi);
        chk("t6_late_bresp", br, 2'b10);

        rd(32'h0, 2'b01, 5'h10, 8'd255, 3'd2, 0, lat);
        chk("len255_beats", got_d.size(), 256);

        araddr = 32'h200; arburst = 2'b01; arid = 5'h11; arlen = 8'd15; arsize = 3'd2; arvalid = 1;
        nb = 0;
        do begin @(negedge clock); nb++; end while (!arready && nb < 200);
        @(posedge clock); #1;
        arvalid = 0; rready = 1;
        repeat (4) @(posedge clock);
        #3 reset_n = 0;
        #1;
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_arready", arready, 0);
        rready = 0;
        repeat (2) @(posedge clock);
        #3 reset_n = 1;
        @(posedge clock); #1;
        chk("post_rst_arready", arready, 1);
        rd(32'h100, 2'b01, 5'h12, 8'd3, 3'd2, 0, lat);
        chk("post_rst_beats", got_d.size(), 4);
        chk("post_rst_last_data", got_d[3], 32'h4);

        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        fork
            wr(32'h800, 2'b01, 5'h13, 8'd7, 3'd2, 8, br, bi);
            rd(32'h200, 2'b01, 5'h14, 8'd15, 3'd2, 2, lat);
        join

        for (int it = 0; it < 60; it++) begin
            ra  = ($urandom_range(4) == 0) ? 32'hFFC0 + 32'($urandom_range(63)) : 32'($urandom_range(32'h7FF));
            sel = $urandom_range(9);
            rb  = (sel < 4) ? 2'b00 : (sel < 9) ? 2'b01 : 2'($urandom_range(2, 3));
            rs  = ($urandom_range(9) == 0) ? 3'($urandom_range(1) * 2 + 1) : 3'd2;
            rl  = 8'($urandom_range(15));
            if ($urandom_range(1) == 0) begin
                nb = int'(rl) + 1;
                if ($urandom_range(7) == 0) nb = (rl != 0 && $urandom_range(1) == 0) ? int'(rl) : int'(rl) + 2;
                for (int i = 0; i < nb; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                wr(ra, rb, 5'($urandom), rl, rs, nb, br, bi);
            end else
                rd(ra, rb, 5'($urandom), rl, rs, $urandom_range(2), lat);
        end

        repeat (3) @(posedge clock);
        chk("r_drained", rq.size(), 0);
        chk("b_drained", bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
